box_renderer: RTL

//   Pixel-drawing datapath that services draw/erase commands from the game state FSM.

---
 rtl/box_renderer_pkg.sv | 9 +
 rtl/box_renderer_if.sv | 35 +++
 rtl/box_raster_counter.sv | 34 +++
 rtl/box_renderer.sv | 105 ++++++++++
 4 files changed

// File: rtl/box_renderer_pkg.sv
// renderer_pkg: shared coordinate/colour widths, default screen size and FSM state encoding
package renderer_pkg;
  localparam int COORD_X_W = 8;
  localparam int COORD_Y_W = 7;
  localparam int COLOUR_W = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  typedef enum logic [1:0] {IDLE, PLOT, DONE, CLEAR} state_t;
endpackage

// File: rtl/box_renderer_if.sv
// box_renderer_if: command handshake from the game FSM plus the pixel port toward the VGA adapter
//   master: drives req/erase/box_x/box_y/box_colour (and clear_req), observes busy/done/vga_*
//   slave : the renderer side
//   CLEAR_SCREEN_EN adds clear_req
interface box_renderer_if;
  import renderer_pkg::*;
`ifdef CLEAR_SCREEN_EN
  logic clear_req;
`endif
  logic req;
  logic erase;
  logic [COORD_X_W-1:0] box_x;
  logic [COORD_Y_W-1:0] box_y;
  logic [COLOUR_W-1:0] box_colour;
  logic busy;
  logic done;
  logic [COORD_X_W-1:0] vga_x;
  logic [COORD_Y_W-1:0] vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic vga_plot;
  modport master (
`ifdef CLEAR_SCREEN_EN
    output clear_req,
`endif
    output req, erase, box_x, box_y, box_colour,
    input busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
`ifdef CLEAR_SCREEN_EN
    input clear_req,
`endif
    input req, erase, box_x, box_y, box_colour,
    output busy, done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/box_raster_counter.sv
// box_raster_counter: 2-D raster sweep counter, dx fastest, wraps to 0 after the last pixel
//   clock, resetn : clock, async active-low reset
//   clr           : zero both counters
//   step          : advance one pixel
//   lim_x, lim_y  : sweep size (dx runs 0..lim_x-1, dy runs 0..lim_y-1)
//   dx, dy, last  : current offsets, high on the final pixel of the sweep
module box_raster_counter
  import renderer_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic                 step,
  input  logic [COORD_X_W-1:0] lim_x,
  input  logic [COORD_Y_W-1:0] lim_y,
  output logic [COORD_X_W-1:0] dx,
  output logic [COORD_Y_W-1:0] dy,
  output logic                 last
);
  logic end_x;
  assign end_x = dx == lim_x - COORD_X_W'(1);
  assign last = end_x && (dy == lim_y - COORD_Y_W'(1));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (clr) begin
      dx <= '0;
      dy <= '0;
    end else if (step) begin
      dx <= end_x ? '0 : dx + COORD_X_W'(1);
      dy <= last ? '0 : end_x ? dy + COORD_Y_W'(1) : dy;
    end
endmodule

// File: rtl/box_renderer.sv
// box_renderer: rasterises one box command into per-pixel VGA writes, then pulses done
//   clock, resetn : clock, async active-low reset
//   bus           : box_renderer_if.slave (command handshake in, VGA pixel port out)
//   CLEAR_SCREEN_EN adds a full-screen background sweep requested by clear_req
module box_renderer
  import renderer_pkg::*;
#(
  parameter int                  BOX_W     = 4,
  parameter int                  BOX_H     = 4,
  parameter int                  SCREEN_W  = DEF_SCREEN_W,
  parameter int                  SCREEN_H  = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input logic           clock,
  input logic           resetn,
  box_renderer_if.slave bus
);
  state_t s, nxt;
  logic start_box, start_clr, step, last, clip;
  logic [COORD_X_W-1:0] bx, lim_x, dx;
  logic [COORD_Y_W-1:0] by, lim_y, dy;
  logic [COLOUR_W-1:0] col;
  logic [COORD_X_W:0] sx;
  logic [COORD_Y_W:0] sy;
  // one bit wider so boxes near the right/bottom edge clip instead of wrapping to 0
  assign sx = {1'b0, bx} + {1'b0, dx};
  assign sy = {1'b0, by} + {1'b0, dy};
  assign clip = (sx >= (COORD_X_W + 1)'(SCREEN_W)) || (sy >= (COORD_Y_W + 1)'(SCREEN_H));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) s <= IDLE;
    else s <= nxt;
  always_comb begin
    nxt = s;
    start_box = 1'b0;
    start_clr = 1'b0;
    step = 1'b0;
    case (s)
      IDLE: begin
`ifdef CLEAR_SCREEN_EN
        start_clr = bus.clear_req;
`endif
        start_box = bus.req && !start_clr;
        nxt = start_clr ? CLEAR : start_box ? PLOT : IDLE;
      end
      PLOT, CLEAR: begin
        step = 1'b1;
        nxt = last ? DONE : s;
      end
      default: nxt = IDLE;
    endcase
  end
  // a clear is just a sweep of a screen-sized box at the origin in the background colour
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      bx <= '0;
      by <= '0;
      col <= '0;
      lim_x <= '0;
      lim_y <= '0;
    end else if (start_box) begin
      bx <= bus.box_x;
      by <= bus.box_y;
      col <= bus.erase ? BG_COLOUR : bus.box_colour;
      lim_x <= COORD_X_W'(BOX_W);
      lim_y <= COORD_Y_W'(BOX_H);
    end
`ifdef CLEAR_SCREEN_EN
    else if (start_clr) begin
      bx <= '0;
      by <= '0;
      col <= BG_COLOUR;
      lim_x <= COORD_X_W'(SCREEN_W);
      lim_y <= COORD_Y_W'(SCREEN_H);
    end
`endif
  box_raster_counter u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clr    (start_box || start_clr),
    .step   (step),
    .lim_x  (lim_x),
    .lim_y  (lim_y),
    .dx     (dx),
    .dy     (dy),
    .last   (last)
  );
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.vga_plot <= 1'b0;
      bus.vga_x <= '0;
      bus.vga_y <= '0;
      bus.vga_colour <= '0;
    end else begin
      bus.busy <= step;
      bus.done <= s == DONE;
      bus.vga_plot <= step && !clip;
      if (step) begin
        bus.vga_x <= sx[COORD_X_W-1:0];
        bus.vga_y <= sy[COORD_Y_W-1:0];
        bus.vga_colour <= col;
      end
    end
endmodule
